// File: rtl/cnt_ctrl_pkg.sv
// Shared encodings for the programmable timer controller.
package cnt_ctrl_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    // Reload behaviour selected by cfg_mode
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider: asserts tick on the clock where the phase counter equals presc.
module tick_prescaler #(
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] presc,
    output logic             tick
);

    logic [PRE_W-1:0] r_count;

    // Tick is combinational so the counter consumes it on the same edge the phase wraps
    assign tick = en && (r_count == presc);

    // Phase counter: cleared by START/STOP, frozen whenever en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == presc) ? '0 : r_count + PRE_W'(1);
        end
    end

endmodule

// File: rtl/cnt_timer_ctrl.sv
// Programmable timer: command-driven FSM sequencing a prescaled up-counter.
module cnt_timer_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic [PRE_W-1:0] cfg_prescale,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    logic [WIDTH-1:0] r_period;
    logic             r_mode;
    logic [PRE_W-1:0] r_presc;

    logic             w_cmd;
    logic             w_start;
    logic             w_stop;
    logic             w_pause;
    logic             w_resume;
    logic             w_presc_clr;
    logic             w_presc_en;
    logic             w_tick;

    // Ready tracks reset directly so it drops the instant rst goes low
    assign cmd_ready = rst;

    assign w_cmd    = cmd_valid & cmd_ready;
    assign w_start  = w_cmd && (cmd_op == OP_START);
    assign w_stop   = w_cmd && (cmd_op == OP_STOP);
    assign w_pause  = w_cmd && (cmd_op == OP_PAUSE);
    assign w_resume = w_cmd && (cmd_op == OP_RESUME);

    // A command that acts this cycle pre-empts the tick, so the phase must not advance
    assign w_presc_clr = w_start | w_stop;
    assign w_presc_en  = (r_state == ST_RUN) & ~w_start & ~w_stop & ~w_pause;

    tick_prescaler #(
        .PRE_W (PRE_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_presc_clr),
        .en    (w_presc_en),
        .presc (r_presc),
        .tick  (w_tick)
    );

    // Next-state, counter and pulse decode; commands take priority over ticks
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_tc_nxt    = 1'b0;

        if (w_start) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick) begin
                        if (r_cnt == r_period) begin
                            w_tc_nxt = 1'b1;
                            if (r_mode == MODE_ONESHOT) begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_cnt_nxt = '0;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + WIDTH'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_resume) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_tc    <= w_tc_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Shadow configuration captured only on START
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period <= '0;
            r_mode   <= MODE_ONESHOT;
            r_presc  <= '0;
        end else if (w_start) begin
            r_period <= cfg_period;
            r_mode   <= cfg_mode;
            r_presc  <= cfg_prescale;
        end
    end

    assign cnt      = r_cnt;
    assign busy     = r_busy;
    assign tc_pulse = r_tc;
    assign done     = r_done;

endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// Self-checking bench for cnt_timer_ctrl: directed scenarios plus random commands
// compared every cycle against a behavioural timer model.
module tb_cnt_timer_ctrl;

    localparam logic [1:0] C_START  = 2'b00;
    localparam logic [1:0] C_STOP   = 2'b01;
    localparam logic [1:0] C_PAUSE  = 2'b10;
    localparam logic [1:0] C_RESUME = 2'b11;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cfg_period;
    logic       cfg_mode;
    logic [3:0] cfg_prescale;
    logic [3:0] cnt;
    logic       busy;
    logic       tc_pulse;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference model: timer described by phase/count integers and activity flags
    int m_cnt, m_ph, m_period, m_presc;
    bit m_periodic, m_run, m_pause, m_done, m_tc;

    cnt_timer_ctrl #(
        .WIDTH (4),
        .PRE_W (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cfg_period   (cfg_period),
        .cfg_mode     (cfg_mode),
        .cfg_prescale (cfg_prescale),
        .cnt          (cnt),
        .busy         (busy),
        .tc_pulse     (tc_pulse),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ph = 0; m_period = 0; m_presc = 0;
        m_periodic = 0; m_run = 0; m_pause = 0; m_done = 0; m_tc = 0;
    endtask

    // One clock edge of the timer, from the command/config inputs currently applied
    task automatic model_edge();
        m_tc = 0;
        if (cmd_valid && cmd_op == C_START) begin
            m_period = int'(cfg_period); m_presc = int'(cfg_prescale); m_periodic = cfg_mode;
            m_cnt = 0; m_ph = 0; m_done = 0; m_run = 1; m_pause = 0;
        end else if (cmd_valid && cmd_op == C_STOP) begin
            m_cnt = 0; m_ph = 0; m_done = 0; m_run = 0; m_pause = 0;
        end else if (cmd_valid && cmd_op == C_PAUSE && m_run) begin
            m_run = 0; m_pause = 1;
        end else if (cmd_valid && cmd_op == C_RESUME && m_pause) begin
            m_run = 1; m_pause = 0;
        end else if (m_run) begin
            if (m_ph == m_presc) begin
                m_ph = 0;
                if (m_cnt == m_period) begin
                    m_tc = 1;
                    if (m_periodic) m_cnt = 0;
                    else begin m_run = 0; m_done = 1; end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_ph = m_ph + 1;
            end
        end
    endtask

    task automatic check_all();
        chk("cnt",       32'(cnt),       32'(m_cnt));
        chk("busy",      32'(busy),      32'(m_run | m_pause));
        chk("tc_pulse",  32'(tc_pulse),  32'(m_tc));
        chk("done",      32'(done),      32'(m_done));
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    // Apply a command (or none) for one clock, then compare just after the edge
    task automatic step(input logic v, input logic [1:0] op);
        cmd_valid = v;
        cmd_op    = op;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, C_START);
    endtask

    // Run until the model count hits target, bounded; DUT must agree at the end
    task automatic run_to_cnt(input int target, input int limit);
        for (int i = 0; i < limit && m_cnt != target; i++) step(1'b0, C_START);
        chk("reach_cnt", 32'(cnt), 32'(target));
    endtask

    task automatic set_cfg(input int p, input logic m, input int ps);
        cfg_period   = 4'(p);
        cfg_mode     = m;
        cfg_prescale = 4'(ps);
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = C_START;
        set_cfg(0, 1'b0, 0);
        model_reset();
        #2;
        chk("rst_cnt",   32'(cnt),       32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        #15 rst = 1'b1;
        #1 chk("rel_ready", 32'(cmd_ready), 32'd1);
        idle(2);

        // Periodic, period 3, no prescale: terminal every 4 clocks
        set_cfg(3, 1'b1, 0);
        step(1'b1, C_START);
        idle(3);
        chk("p3_no_tc", 32'(tc_pulse), 32'd0);
        idle(1);
        chk("p3_tc1", 32'(tc_pulse), 32'd1);
        chk("p3_wrap", 32'(cnt), 32'd0);
        idle(4);
        chk("p3_tc2", 32'(tc_pulse), 32'd1);
        chk("p3_busy", 32'(busy), 32'd1);

        // One-shot, period 5, prescale 2: terminal 18 clocks after START
        set_cfg(5, 1'b0, 2);
        step(1'b1, C_START);
        idle(17);
        chk("os_pre_tc",   32'(tc_pulse), 32'd0);
        chk("os_pre_done", 32'(done),     32'd0);
        idle(1);
        chk("os_tc",   32'(tc_pulse), 32'd1);
        chk("os_done", 32'(done),     32'd1);
        chk("os_busy", 32'(busy),     32'd0);
        chk("os_cnt",  32'(cnt),      32'd5);
        step(1'b1, C_RESUME);
        chk("os_res_cnt",  32'(cnt),  32'd5);
        chk("os_res_busy", 32'(busy), 32'd0);
        chk("os_res_done", 32'(done), 32'd1);
        idle(3);

        // Pause/resume, period 7, prescale 1, config edits while paused
        set_cfg(7, 1'b1, 1);
        step(1'b1, C_START);
        run_to_cnt(2, 20);
        set_cfg(1, 1'b0, 0);
        step(1'b1, C_PAUSE);
        idle(10);
        chk("pause_cnt", 32'(cnt), 32'd2);
        step(1'b1, C_RESUME);
        idle(2);
        chk("resume_cnt", 32'(cnt), 32'd3);
        idle(20);

        // STOP on a terminal-tick edge
        set_cfg(3, 1'b1, 0);
        step(1'b1, C_START);
        run_to_cnt(3, 10);
        step(1'b1, C_STOP);
        chk("stop_tc",   32'(tc_pulse), 32'd0);
        chk("stop_cnt",  32'(cnt),      32'd0);
        chk("stop_busy", 32'(busy),     32'd0);
        chk("stop_done", 32'(done),     32'd0);
        idle(2);

        // START on a terminal-tick edge
        step(1'b1, C_START);
        run_to_cnt(3, 10);
        set_cfg(2, 1'b1, 0);
        step(1'b1, C_START);
        chk("restart_tc",  32'(tc_pulse), 32'd0);
        chk("restart_cnt", 32'(cnt),      32'd0);
        idle(6);

        // period 0, prescale 3: pulse every 4 clocks, count stuck at 0
        set_cfg(0, 1'b1, 3);
        step(1'b1, C_START);
        idle(4);
        chk("p0_tc", 32'(tc_pulse), 32'd1);
        idle(4);
        chk("p0_tc2", 32'(tc_pulse), 32'd1);
        chk("p0_cnt", 32'(cnt), 32'd0);

        // Full range, period 15, no prescale
        set_cfg(15, 1'b1, 0);
        step(1'b1, C_START);
        idle(15);
        chk("full_cnt15", 32'(cnt), 32'd15);
        chk("full_no_tc", 32'(tc_pulse), 32'd0);
        idle(1);
        chk("full_tc",   32'(tc_pulse), 32'd1);
        chk("full_wrap", 32'(cnt), 32'd0);
        idle(5);

        // Asynchronous reset mid-cycle while running
        #3 rst = 1'b0;
        #1;
        chk("arst_cnt",   32'(cnt),       32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_tc",    32'(tc_pulse),  32'd0);
        chk("arst_done",  32'(done),      32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd0);
        model_reset();
        #2 rst = 1'b1;
        #1 chk("arst_rel_ready", 32'(cmd_ready), 32'd1);
        idle(3);

        // Random commands and configuration churn
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_cfg(($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 4)),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            end
            step(1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
